// File: rtl/cache_l2_setassoc.sv
// N-way set-associative write-back/write-allocate L2, one word per line, true LRU.
// Ports: core req/resp handshake, flush/flush_done, dmem req (we/addr/wdata) + refill rvalid/rdata.
module cache_l2_setassoc #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 256,
  parameter int WAYS   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  input  logic              flush,
  output logic              flush_done,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WBACK, S_REFILL_REQ,
    S_REFILL_WAIT, S_RESPOND, S_FLUSH_SCAN, S_FLUSH_WB
  } state_t;

  state_t state, nstate;

  logic              vld [SETS][WAYS];
  logic              drt [SETS][WAYS];
  logic [WAY_W-1:0]  age [SETS][WAYS];
  logic [TAG_W-1:0]  tgm [SETS][WAYS];
  logic [DATA_W-1:0] dat [SETS][WAYS];

  logic              r_we;
  logic [ADDR_W-3:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [WAY_W-1:0]  vic_q;
  logic [DATA_W-1:0] rdata_q;
  logic [IDX_W-1:0]  fl_set;
  logic [WAY_W-1:0]  fl_way;

  logic [IDX_W-1:0]  ridx;
  logic [TAG_W-1:0]  rtag;
  logic              hit;
  logic [WAY_W-1:0]  hway;
  logic [WAY_W-1:0]  vic;
  logic              vfound;
  logic              fl_last;
  logic [WAY_W-1:0]  tch_old;

  logic              lat_req, set_vic, cap;
  logic              tch_en, ln_we, ln_dirty;
  logic [WAY_W-1:0]  tch_way, ln_way;
  logic [DATA_W-1:0] ln_data;
  logic              cd_en;
  logic [IDX_W-1:0]  cd_set;
  logic [WAY_W-1:0]  cd_way;
  logic              fl_init, fl_step, fl_clr;

  logic unused_bits;
  assign unused_bits = ^req_addr[1:0];

  assign ridx    = r_addr[0+:IDX_W];
  assign rtag    = r_addr[ADDR_W-3:IDX_W];
  assign fl_last = (fl_set == IDX_W'(SETS - 1)) && (fl_way == AGE_MAX);
  // An invalid way being filled counts as the oldest.
  assign tch_old = vld[ridx][tch_way] ? age[ridx][tch_way] : AGE_MAX;

  always_comb begin
    hit    = 1'b0;
    hway   = '0;
    vic    = '0;
    vfound = 1'b0;
    for (int j = 0; j < WAYS; j++) begin
      if (vld[ridx][j] && tgm[ridx][j] == rtag) begin
        hit  = 1'b1;
        hway = WAY_W'(j);
      end
    end
    for (int j = 0; j < WAYS; j++) begin
      if (!vfound && !vld[ridx][j]) begin
        vfound = 1'b1;
        vic    = WAY_W'(j);
      end
    end
    if (!vfound) begin
      for (int j = 0; j < WAYS; j++) begin
        if (age[ridx][j] == AGE_MAX) vic = WAY_W'(j);
      end
    end
  end

  always_comb begin
    nstate        = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    resp_hit      = 1'b0;
    flush_done    = 1'b0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    lat_req       = 1'b0;
    set_vic       = 1'b0;
    cap           = 1'b0;
    tch_en        = 1'b0;
    tch_way       = '0;
    ln_we         = 1'b0;
    ln_way        = '0;
    ln_data       = '0;
    ln_dirty      = 1'b0;
    cd_en         = 1'b0;
    cd_set        = '0;
    cd_way        = '0;
    fl_init       = 1'b0;
    fl_step       = 1'b0;
    fl_clr        = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (flush) begin
          fl_init = 1'b1;
          nstate  = S_FLUSH_SCAN;
        end else if (req_valid) begin
          lat_req = 1'b1;
          nstate  = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_hit   = 1'b1;
          tch_en     = 1'b1;
          tch_way    = hway;
          if (r_we) begin
            ln_we    = 1'b1;
            ln_way   = hway;
            ln_data  = r_wdata;
            ln_dirty = 1'b1;
          end else begin
            resp_rdata = dat[ridx][hway];
          end
          nstate = S_IDLE;
        end else begin
          set_vic = 1'b1;
          if (vld[ridx][vic] && drt[ridx][vic]) begin
            nstate = S_WBACK;
          end else if (!r_we) begin
            nstate = S_REFILL_REQ;
          end else begin
            ln_we    = 1'b1;
            ln_way   = vic;
            ln_data  = r_wdata;
            ln_dirty = 1'b1;
            tch_en   = 1'b1;
            tch_way  = vic;
            nstate   = S_RESPOND;
          end
        end
      end
      S_WBACK: begin
        mem_req_valid = 1'b1;
        mem_we        = 1'b1;
        mem_addr      = {tgm[ridx][vic_q], ridx, 2'b00};
        mem_wdata     = dat[ridx][vic_q];
        if (mem_req_ready) begin
          cd_en  = 1'b1;
          cd_set = ridx;
          cd_way = vic_q;
          if (!r_we) begin
            nstate = S_REFILL_REQ;
          end else begin
            ln_we    = 1'b1;
            ln_way   = vic_q;
            ln_data  = r_wdata;
            ln_dirty = 1'b1;
            tch_en   = 1'b1;
            tch_way  = vic_q;
            nstate   = S_RESPOND;
          end
        end
      end
      S_REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = {r_addr, 2'b00};
        if (mem_req_ready) nstate = S_REFILL_WAIT;
      end
      S_REFILL_WAIT: begin
        if (mem_rvalid) begin
          ln_we   = 1'b1;
          ln_way  = vic_q;
          ln_data = mem_rdata;
          tch_en  = 1'b1;
          tch_way = vic_q;
          cap     = 1'b1;
          nstate  = S_RESPOND;
        end
      end
      S_RESPOND: begin
        resp_valid = 1'b1;
        resp_rdata = r_we ? '0 : rdata_q;
        nstate     = S_IDLE;
      end
      S_FLUSH_SCAN: begin
        // Dirty lines detour through FLUSH_WB and are cleared on return.
        if (vld[fl_set][fl_way] && drt[fl_set][fl_way]) begin
          nstate = S_FLUSH_WB;
        end else begin
          fl_clr = 1'b1;
          if (fl_last) begin
            flush_done = 1'b1;
            nstate     = S_IDLE;
          end else begin
            fl_step = 1'b1;
          end
        end
      end
      S_FLUSH_WB: begin
        mem_req_valid = 1'b1;
        mem_we        = 1'b1;
        mem_addr      = {tgm[fl_set][fl_way], fl_set, 2'b00};
        mem_wdata     = dat[fl_set][fl_way];
        if (mem_req_ready) begin
          cd_en  = 1'b1;
          cd_set = fl_set;
          cd_way = fl_way;
          nstate = S_FLUSH_SCAN;
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      vic_q   <= '0;
      rdata_q <= '0;
      fl_set  <= '0;
      fl_way  <= '0;
    end else begin
      state <= nstate;
      if (lat_req) begin
        r_we    <= req_we;
        r_addr  <= req_addr[ADDR_W-1:2];
        r_wdata <= req_wdata;
      end
      if (set_vic) vic_q <= vic;
      if (cap) rdata_q <= mem_rdata;
      if (fl_init) begin
        fl_set <= '0;
        fl_way <= '0;
      end else if (fl_step) begin
        if (fl_way == AGE_MAX) begin
          fl_way <= '0;
          fl_set <= fl_set + 1'b1;
        end else begin
          fl_way <= fl_way + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          vld[s][w] <= 1'b0;
          drt[s][w] <= 1'b0;
          age[s][w] <= '0;
        end
      end
    end else begin
      if (cd_en) drt[cd_set][cd_way] <= 1'b0;
      if (fl_clr) begin
        vld[fl_set][fl_way] <= 1'b0;
        drt[fl_set][fl_way] <= 1'b0;
        age[fl_set][fl_way] <= '0;
      end
      if (tch_en) begin
        for (int j = 0; j < WAYS; j++) begin
          if (WAY_W'(j) == tch_way)
            age[ridx][j] <= '0;
          else if (vld[ridx][j] && age[ridx][j] < tch_old)
            age[ridx][j] <= age[ridx][j] + 1'b1;
        end
      end
      // Install overrides the victim's dirty clear in the same cycle.
      if (ln_we) begin
        vld[ridx][ln_way] <= 1'b1;
        drt[ridx][ln_way] <= ln_dirty;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ln_we) begin
      tgm[ridx][ln_way] <= rtag;
      dat[ridx][ln_way] <= ln_data;
    end
  end

endmodule

// File: tb/tb_cache_l2_setassoc.sv
// Directed bench for cache_l2_setassoc: vector table plus stall, flush
// and mid-refill reset sequences against a simple dmem model.
module tb_cache_l2_setassoc;

  localparam int SETS = 256;
  localparam int WAYS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_hit;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  cache_l2_setassoc #(
    .ADDR_W(32), .DATA_W(32), .SETS(SETS), .WAYS(WAYS)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .flush(flush), .flush_done(flush_done),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // dmem model
  logic        mem_ready_en = 1'b1;
  assign mem_req_ready = mem_ready_en;
  int          rdelay = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;
  logic [31:0] mem_m [logic [31:0]];
  logic        pend = 1'b0;
  int          pcnt = 0;
  logic [31:0] pdata = '0;

  always @(posedge clk) begin
    mem_rvalid <= 1'b0;
    if (pend) begin
      if (pcnt == 0) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= pdata;
        pend       <= 1'b0;
      end else begin
        pcnt <= pcnt - 1;
      end
    end
    if (mem_req_valid && mem_req_ready) begin
      if (mem_we) begin
        wr_cnt++;
        last_wa = mem_addr;
        last_wd = mem_wdata;
        mem_m[mem_addr] = mem_wdata;
      end else begin
        rd_cnt++;
        pend  <= 1'b1;
        pcnt  <= rdelay;
        pdata <= mem_m.exists(mem_addr) ? mem_m[mem_addr]
                                         : (mem_addr ^ 32'h5A5A_0000);
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    int          rd;
    int          wr;
    logic [31:0] wa;
    logic [31:0] wd;
  } vec_t;

  vec_t v[20];

  task automatic do_req(input logic we, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic h, output int lat);
    @(negedge clk);
    chk("idle_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1;
    rd  = '0;
    h   = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        rd  = resp_rdata;
        h   = resp_hit;
        lat = n;
        break;
      end
    end
    if (lat < 0) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input int lo, input int hi);
    logic [31:0] rd;
    logic        h;
    int          lat, r0, w0;
    for (int i = lo; i <= hi; i++) begin
      r0 = rd_cnt;
      w0 = wr_cnt;
      do_req(v[i].we, v[i].addr, v[i].wdata, rd, h, lat);
      chk($sformatf("v%0d_hit", i), {31'b0, h}, {31'b0, v[i].hit});
      chk($sformatf("v%0d_rdata", i), rd, v[i].rdata);
      chk($sformatf("v%0d_rd", i), 32'(rd_cnt - r0), 32'(v[i].rd));
      chk($sformatf("v%0d_wr", i), 32'(wr_cnt - w0), 32'(v[i].wr));
      if (v[i].wr == 1) begin
        chk($sformatf("v%0d_wa", i), last_wa, v[i].wa);
        chk($sformatf("v%0d_wd", i), last_wd, v[i].wd);
      end
      if (v[i].hit) chk($sformatf("v%0d_lat", i), 32'(lat), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        h;
    int          lat, w0, r0, cyc;
    logic        done, seen;

    // we addr wdata rdata hit rd wr wa wd
    v[0]  = '{0, 32'h100,  0, 32'hDEADBEEF, 0, 1, 0, 0, 0};
    v[1]  = '{0, 32'h100,  0, 32'hDEADBEEF, 1, 0, 0, 0, 0};
    v[2]  = '{1, 32'h200,  32'h11, 0, 0, 0, 0, 0, 0};
    v[3]  = '{0, 32'h200,  0, 32'h11, 1, 0, 0, 0, 0};
    v[4]  = '{1, 32'h400,  32'hA4, 0, 0, 0, 0, 0, 0};
    v[5]  = '{1, 32'h800,  32'hA8, 0, 0, 0, 0, 0, 0};
    v[6]  = '{0, 32'h400,  0, 32'hA4, 1, 0, 0, 0, 0};
    v[7]  = '{1, 32'hC00,  32'hAC, 0, 0, 0, 1, 32'h800, 32'hA8};
    v[8]  = '{0, 32'h400,  0, 32'hA4, 1, 0, 0, 0, 0};
    v[9]  = '{0, 32'hC00,  0, 32'hAC, 1, 0, 0, 0, 0};
    v[10] = '{0, 32'h800,  0, 32'hA8, 0, 1, 1, 32'h400, 32'hA4};
    v[11] = '{0, 32'h404,  0, 32'h5A5A0404, 0, 1, 0, 0, 0};
    v[12] = '{1, 32'h300,  32'h33, 0, 0, 0, 0, 0, 0};
    v[13] = '{0, 32'h200,  0, 32'h11, 0, 1, 0, 0, 0};
    v[14] = '{0, 32'h1000, 0, 32'h10000001, 0, 1, 0, 0, 0};
    v[15] = '{0, 32'h300,  0, 32'h33, 0, 1, 0, 0, 0};
    v[16] = '{0, 32'h100,  0, 32'hDEADBEEF, 0, 1, 0, 0, 0};
    v[17] = '{0, 32'h500,  0, 32'h5A5A0500, 0, 1, 0, 0, 0};
    v[18] = '{0, 32'h100,  0, 32'hDEADBEEF, 0, 1, 0, 0, 0};
    v[19] = '{0, 32'h500,  0, 32'h5A5A0500, 1, 0, 0, 0, 0};

    mem_m[32'h100] = 32'hDEADBEEF;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_flush_done", {31'b0, flush_done}, 32'd0);
    reset = 1'b1;

    run_vec(0, 12);

    // dmem stalls a write-back of dirty 0xC00
    w0 = wr_cnt;
    mem_ready_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h1000;
    req_wdata = 32'h10000001;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_mvalid", {31'b0, mem_req_valid}, 32'd1);
      chk("stall_mwe", {31'b0, mem_we}, 32'd1);
      chk("stall_maddr", mem_addr, 32'hC00);
      chk("stall_mwdata", mem_wdata, 32'hAC);
      chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
    end
    mem_ready_en = 1'b1;
    seen = 1'b0;
    h = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        h = resp_hit;
        break;
      end
    end
    chk("stall_resp", {31'b0, seen}, 32'd1);
    chk("stall_hit", {31'b0, h}, 32'd0);
    chk("stall_wr", 32'(wr_cnt - w0), 32'd1);
    chk("stall_wa", last_wa, 32'hC00);

    // flush with a simultaneous request: 3 dirty lines
    w0 = wr_cnt;
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h100;
    @(posedge clk);
    #1 flush = 1'b0;
    req_valid = 1'b0;
    done = 1'b0;
    seen = 1'b0;
    cyc  = 0;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
      if (flush_done) begin
        done = 1'b1;
        cyc  = n;
        break;
      end
    end
    chk("flush_done", {31'b0, done}, 32'd1);
    chk("flush_no_resp", {31'b0, seen}, 32'd0);
    chk("flush_wr", 32'(wr_cnt - w0), 32'd3);
    chk("flush_len_min", {31'b0, cyc >= SETS * WAYS}, 32'd1);
    chk("flush_len_max", {31'b0, cyc < SETS * WAYS + 20}, 32'd1);
    @(negedge clk);
    chk("flush_pulse", {31'b0, flush_done}, 32'd0);

    run_vec(13, 16);

    // reset while waiting on refill data
    rdelay = 20;
    r0 = rd_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h500;
    @(posedge clk);
    #1 req_valid = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rd_cnt != r0) begin
        done = 1'b1;
        break;
      end
    end
    chk("rwait_reached", {31'b0, done}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rwait_rst_mvalid", {31'b0, mem_req_valid}, 32'd0);
    chk("rwait_rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rwait_rst_resp", {31'b0, resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (resp_valid || mem_req_valid) seen = 1'b1;
    end
    chk("rwait_quiet", {31'b0, seen}, 32'd0);
    rdelay = 0;

    run_vec(17, 19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
